uart_rx_word_packer: RTL

- Sits directly downstream of the UART receiver.
- Consumes its per-character data bus and one-cycle "character received" strobe, and packs BYTES_PER_WORD consecutive characters into one WORD_BITS word.
- Presents each word on a valid/ready interface for the MIPS program loader / memory-write path.
- Provides an inter-character gap timeout that discards partial words, plus a sticky overflow flag for characters that arrive while a completed word cannot be delivered.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_word_packer_if.sv | 28 ++
 rtl/uart_gap_timer.sv | 32 +++
 rtl/uart_rx_word_packer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: packer state encoding and
// the bit-clock constants used to size the default inter-character timeout.
package uart_pkg;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    localparam int CLK_FREQ     = 100_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    // Four character times (start + 8 data + stop = 10 bits per character).
    function automatic int default_timeout_clks(input int clks_per_bit);
        int char_clks;
        char_clks = 10 * clks_per_bit;
        return char_clks * 4;
    endfunction

    localparam int DEFAULT_TIMEOUT_CLKS = default_timeout_clks(CLKS_PER_BIT);

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Character-in / word-out bus of the UART word packer. The master side is the
// packer itself; the slave side is the receiver plus the word consumer.
interface uart_rx_word_packer_if #(
    parameter int DATA_BITS = 8,
    parameter int WORD_BITS = 32
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [WORD_BITS-1:0] word_data;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  word_ready,
        output word_data,
        output word_valid
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output word_ready,
        input  word_data,
        input  word_valid
    );
endinterface

// File: rtl/uart_gap_timer.sv
// Saturating idle counter that flags expiry after TIMEOUT_CLKS run cycles.
// TIMEOUT_CLKS = 0 means the timer never expires.
module uart_gap_timer #(
    parameter int TIMEOUT_CLKS = uart_pkg::DEFAULT_TIMEOUT_CLKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CLKS);

    logic [TW-1:0] count_r;

    // Idle counter: clear wins, otherwise count up and hold at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (run && (count_r != LIMIT)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (TIMEOUT_CLKS > 0) && (count_r == LIMIT);

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs BYTES_PER_WORD received UART characters into one word presented on a
// valid/ready slot, with gap-timeout discard and a sticky overflow flag.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int WORD_BITS      = DATA_BITS * BYTES_PER_WORD,
    parameter int LITTLE_ENDIAN  = 1,
    parameter int TIMEOUT_CLKS   = DEFAULT_TIMEOUT_CLKS,
    localparam int CW            = $clog2(BYTES_PER_WORD) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_word_packer_if.master  bus,
    output logic [CW-1:0]          byte_count,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic                   timeout_pulse
);
    logic                 state_r, state_next_s;
    logic [CW-1:0]        byte_count_r;
    logic [WORD_BITS-1:0] asm_r;
    logic [WORD_BITS-1:0] word_data_r;
    logic                 word_valid_r;
    logic                 overflow_r;
    logic                 timeout_pulse_r;

    logic                 slot_free_s, last_char_s, expire_s;
    logic [CW-1:0]        lane_s;
    logic [WORD_BITS-1:0] asm_with_char_s;
    logic store_char_s, load_direct_s, hold_word_s, load_pending_s;
    logic drop_char_s, discard_s, timer_clear_s, timer_run_s;

    assign slot_free_s = !word_valid_r || bus.word_ready;
    assign last_char_s = (byte_count_r == CW'(BYTES_PER_WORD - 1));

    // Merge the incoming character into its lane of the assembly register.
    always_comb begin
        if (LITTLE_ENDIAN != 0) begin
            lane_s = byte_count_r;
        end else begin
            lane_s = CW'(BYTES_PER_WORD - 1) - byte_count_r;
        end
        asm_with_char_s = asm_r;
        asm_with_char_s[lane_s*DATA_BITS +: DATA_BITS] = bus.rx_data;
    end

    uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expire (expire_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a blocked full word parks in PENDING until the slot frees.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_COLLECT: state_next_s = hold_word_s ? ST_PENDING : ST_COLLECT;
            ST_PENDING: state_next_s = slot_free_s ? ST_COLLECT : ST_PENDING;
            default:    state_next_s = ST_COLLECT;
        endcase
    end

    // Per-state control strobes; an arriving character beats a same-cycle expiry.
    always_comb begin
        store_char_s   = 1'b0;
        load_direct_s  = 1'b0;
        hold_word_s    = 1'b0;
        load_pending_s = 1'b0;
        drop_char_s    = 1'b0;
        discard_s      = 1'b0;
        timer_clear_s  = 1'b0;
        timer_run_s    = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (bus.rx_valid) begin
                    timer_clear_s = 1'b1;
                    if (!last_char_s) begin
                        store_char_s = 1'b1;
                    end else if (slot_free_s) begin
                        load_direct_s = 1'b1;
                    end else begin
                        hold_word_s = 1'b1;
                    end
                end else if (byte_count_r == '0) begin
                    timer_clear_s = 1'b1;
                end else if (expire_s) begin
                    discard_s     = 1'b1;
                    timer_clear_s = 1'b1;
                end else begin
                    timer_run_s = 1'b1;
                end
            end
            ST_PENDING: begin
                timer_clear_s  = 1'b1;
                drop_char_s    = bus.rx_valid;
                load_pending_s = slot_free_s;
            end
            default: begin
                timer_clear_s = 1'b1;
            end
        endcase
    end

    // Assembly register and character count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_r        <= '0;
            byte_count_r <= '0;
        end else if (store_char_s) begin
            asm_r        <= asm_with_char_s;
            byte_count_r <= byte_count_r + CW'(1);
        end else if (hold_word_s) begin
            asm_r        <= asm_with_char_s;
            byte_count_r <= CW'(BYTES_PER_WORD);
        end else if (load_direct_s || load_pending_s || discard_s) begin
            asm_r        <= '0;
            byte_count_r <= '0;
        end else begin
            asm_r        <= asm_r;
            byte_count_r <= byte_count_r;
        end
    end

    // Output slot: a load at the handshake edge keeps word_valid high (no bubble).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_data_r  <= '0;
            word_valid_r <= 1'b0;
        end else if (load_direct_s) begin
            word_data_r  <= asm_with_char_s;
            word_valid_r <= 1'b1;
        end else if (load_pending_s) begin
            word_data_r  <= asm_r;
            word_valid_r <= 1'b1;
        end else if (word_valid_r && bus.word_ready) begin
            word_data_r  <= word_data_r;
            word_valid_r <= 1'b0;
        end else begin
            word_data_r  <= word_data_r;
            word_valid_r <= word_valid_r;
        end
    end

    // Sticky overflow (set beats clear) and the one-cycle timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r      <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            if (drop_char_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            timeout_pulse_r <= discard_s;
        end
    end

    assign bus.word_data  = word_data_r;
    assign bus.word_valid = word_valid_r;
    assign byte_count     = byte_count_r;
    assign overflow       = overflow_r;
    assign timeout_pulse  = timeout_pulse_r;

endmodule
